// File: rtl/mem_data_lsu.sv
// mem_data_lsu: load/store unit in front of a word-organised data memory.
// Turns byte-addressed CPU loads/stores into word accesses. Sub-word loads are
// lane-extracted and sign/zero extended; sub-word stores are read-modify-write
// because the memory has no byte enables. Misaligned and reserved-size requests
// get an error response without touching memory.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready               CPU request handshake
//   req_we, req_size, req_signed      store flag, 00 byte/01 half/10 word, load extension
//   req_addr, req_wdata               byte address, right-aligned store data
//   resp_valid/resp_ready             response handshake
//   resp_rdata, resp_err              extended load data (0 for stores/errors), error flag
//   mem_addr, mem_wr, mem_wdata       word address, write strobe, write data
//   mem_rdata                         combinational read data for mem_addr
module mem_data_lsu #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_t;

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_merged;

  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

  always_comb begin
    w_misaligned = 1'b0;
    unique case (req_size)
      SzByte:  w_misaligned = 1'b0;
      SzHalf:  w_misaligned = req_addr[0];
      SzWord:  w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign w_shift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = mem_rdata;
    if (r_size == SzByte) begin
      w_load = {{(DATA_WIDTH-8){r_signed & w_shift[7]}}, w_shift[7:0]};
    end else if (r_size == SzHalf) begin
      w_load = {{(DATA_WIDTH-16){r_signed & w_shift[15]}}, w_shift[15:0]};
    end
  end

  // Old word with only the target lane(s) replaced by the low store bits.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SzByte) begin
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_size == SzHalf) begin
      w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_merged   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_signed   <= req_signed;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
            r_rdata    <= '0;
            r_err      <= w_misaligned;
            r_state    <= w_misaligned ? StResp : StAccess;
          end
        end
        StAccess: begin
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= StResp;
          end else if (r_size == SzWord) begin
            r_state <= StResp;
          end else begin
            r_merged <= w_merged;
            r_state  <= StWrite;
          end
        end
        StWrite: begin
          r_state <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = (r_state == StResp);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_mem_addr;

  // Decoded from registered state only, so reset drops the strobe immediately.
  assign mem_wr    = ((r_state == StAccess) && r_we && (r_size == SzWord)) ||
                     (r_state == StWrite);
  assign mem_wdata = (r_state == StWrite) ? r_merged : r_wdata;

endmodule

// File: tb/tb_mem_data_lsu.sv
// Directed self-checking bench for mem_data_lsu with a simple word memory model.
module tb_mem_data_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  // Results of the last transaction.
  int          wr_cnt;
  int          wr_cyc;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;
  int          resp_cyc;
  logic [31:0] got_rdata;
  logic        got_err;

  mem_data_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to the response; cycle 1 is the cycle after the accept edge.
  task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [9:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wr_cnt    = 0;
    wr_cyc    = 0;
    wr_data   = '0;
    wr_addr   = '0;
    resp_cyc  = 0;
    got_rdata = '0;
    got_err   = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (mem_wr) begin
        wr_cnt++;
        wr_cyc  = cyc;
        wr_data = mem_wdata;
        wr_addr = {24'h0, mem_addr};
      end
      if (resp_valid) begin
        resp_cyc  = cyc;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (resp_cyc == 0) check("resp_timeout", 32'd0, 32'd1);
    // resp_ready is high, so the response handshakes at the next edge.
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string tag, input logic [31:0] exp);
    check({tag, "_rdata"}, got_rdata, exp);
    check({tag, "_cyc"}, resp_cyc, 32'd2);
    check({tag, "_err"}, {31'h0, got_err}, 32'd0);
    check({tag, "_nowr"}, wr_cnt, 32'd0);
  endtask

  task automatic check_misaligned(input string tag);
    check({tag, "_err"}, {31'h0, got_err}, 32'd1);
    check({tag, "_rdata"}, got_rdata, 32'd0);
    check({tag, "_cyc"}, resp_cyc, 32'd1);
    check({tag, "_nowr"}, wr_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          bp_wr;
    int          bp_bad;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    #23;
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'h0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load.
    txn(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
    check("sw_wr_cnt", wr_cnt, 32'd1);
    check("sw_wr_cyc", wr_cyc, 32'd1);
    check("sw_wr_addr", wr_addr, 32'd4);
    check("sw_wr_data", wr_data, 32'hDEADBEEF);
    check("sw_resp_cyc", resp_cyc, 32'd2);
    check("sw_rdata", got_rdata, 32'd0);
    check("sw_err", {31'h0, got_err}, 32'd0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    check("sw_ready_after", {31'h0, req_ready}, 32'd1);
    txn(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    check_load("lw", 32'hDEADBEEF);

    // Byte RMW store; upper wdata bits must be ignored.
    mem[4] = 32'h11223344;
    txn(1'b1, 2'b00, 1'b0, 10'h012, 32'h123456AB);
    check("sb_wr_cnt", wr_cnt, 32'd1);
    check("sb_wr_cyc", wr_cyc, 32'd2);
    check("sb_wr_data", wr_data, 32'h11AB3344);
    check("sb_wr_addr", wr_addr, 32'd4);
    check("sb_resp_cyc", resp_cyc, 32'd3);
    check("sb_rdata", got_rdata, 32'd0);
    check("sb_mem", mem[4], 32'h11AB3344);

    // Half RMW store into the upper half.
    mem[5] = 32'hCAFEF00D;
    txn(1'b1, 2'b01, 1'b0, 10'h016, 32'h00001234);
    check("sh_wr_data", wr_data, 32'h1234F00D);
    check("sh_wr_cyc", wr_cyc, 32'd2);
    check("sh_resp_cyc", resp_cyc, 32'd3);

    // Sign/zero extension.
    mem[4] = 32'h80FF7F01;
    txn(1'b0, 2'b00, 1'b1, 10'h011, 32'h0);
    check_load("lb_s_11", 32'h0000007F);
    txn(1'b0, 2'b00, 1'b1, 10'h012, 32'h0);
    check_load("lb_s_12", 32'hFFFFFFFF);
    txn(1'b0, 2'b00, 1'b0, 10'h012, 32'h0);
    check_load("lb_u_12", 32'h000000FF);
    txn(1'b0, 2'b01, 1'b0, 10'h012, 32'h0);
    check_load("lh_u_12", 32'h000080FF);
    txn(1'b0, 2'b01, 1'b1, 10'h012, 32'h0);
    check_load("lh_s_12", 32'hFFFF80FF);
    txn(1'b0, 2'b01, 1'b1, 10'h010, 32'h0);
    check_load("lh_s_10", 32'h00007F01);
    txn(1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
    check_load("lb_s_13", 32'hFFFFFF80);

    // Misaligned / reserved.
    txn(1'b0, 2'b10, 1'b0, 10'h011, 32'h0);
    check_misaligned("mis_lw_11");
    txn(1'b1, 2'b01, 1'b0, 10'h013, 32'hFFFF);
    check_misaligned("mis_sh_13");
    txn(1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    check_misaligned("mis_sz11");
    txn(1'b1, 2'b10, 1'b0, 10'h012, 32'h55555555);
    check_misaligned("mis_sw_12");
    check("mis_mem", mem[4], 32'h80FF7F01);

    // Backpressure: response held, new request refused.
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 10'h010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_valid", {31'h0, resp_valid}, 32'd1);
    held   = resp_rdata;
    check("bp_rdata", held, 32'h80FF7F01);
    bp_wr  = 0;
    bp_bad = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 10'h010;
      req_wdata = 32'h0BADF00D;
      if (mem_wr) bp_wr++;
      if (!resp_valid || resp_rdata !== held || req_ready || resp_err) bp_bad++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("bp_stable", bp_bad, 32'd0);
    check("bp_nowr", bp_wr, 32'd0);
    check("bp_still_valid", {31'h0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done_valid", {31'h0, resp_valid}, 32'd0);
    check("bp_done_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_not_accepted", {31'h0, req_ready}, 32'd1);
    check("bp_mem", mem[4], 32'h80FF7F01);

    // Reset during ACCESS of a byte store.
    mem[4] = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 10'h012;
    req_wdata = 32'h000000AB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ra_in_access", {31'h0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("ra_mem_wr", {31'h0, mem_wr}, 32'd0);
    check("ra_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ra_mem", mem[4], 32'h11223344);
    check("ra_ready_after", {31'h0, req_ready}, 32'd1);
    check("ra_valid_after", {31'h0, resp_valid}, 32'd0);
    check("ra_mem_addr", {24'h0, mem_addr}, 32'd0);

    // Unit still works after the abort.
    txn(1'b0, 2'b00, 1'b0, 10'h012, 32'h0);
    check_load("post_rst_lb", 32'h00000022);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
